// File: rtl/signal_consumer.sv
// signal_consumer: 2-entry stream FIFO whose downstream pops feed a running
// sum and count of consumed words. Optional macro SIGNAL_CONSUMER_PARITY_EN adds
// an even-parity bit stored with each word and a sticky parity_err flag.
module signal_consumer #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              clear,
`ifdef SIGNAL_CONSUMER_PARITY_EN
    input  logic              in_parity,
    output logic              parity_err,
`endif
    output logic [CNT_W-1:0]  sum,
    output logic [CNT_W-1:0]  count
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_t;

`ifdef SIGNAL_CONSUMER_PARITY_EN
    localparam int EntW = DATA_W + 1;
`else
    localparam int EntW = DATA_W;
`endif

    state_t            r_state;
    state_t            w_state_next;
    logic [EntW-1:0]   r_head;
    logic [EntW-1:0]   r_tail;
    logic [EntW-1:0]   w_head_next;
    logic [EntW-1:0]   w_tail_next;
    logic [EntW-1:0]   w_in_entry;
    logic              r_in_ready;
    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  r_sum;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_head_ext;

`ifdef SIGNAL_CONSUMER_PARITY_EN
    assign w_in_entry = {in_parity, in_data};
`else
    assign w_in_entry = in_data;
`endif

    assign in_ready   = r_in_ready;
    assign out_valid  = (r_state != StEmpty);
    assign out_data   = r_head[DATA_W-1:0];
    assign w_push     = in_valid & r_in_ready;
    assign w_pop      = out_valid & out_ready;
    assign w_head_ext = CNT_W'(out_data);
    assign sum        = r_sum;
    assign count      = r_count;

    // Next FIFO state and storage; the head register always holds the oldest word.
    always_comb begin
        w_state_next = r_state;
        w_head_next  = r_head;
        w_tail_next  = r_tail;
        unique case (r_state)
            StEmpty: begin
                if (w_push) begin
                    w_head_next  = w_in_entry;
                    w_state_next = StOne;
                end
            end
            StOne: begin
                if (w_push && w_pop) begin
                    w_head_next = w_in_entry;
                end else if (w_push) begin
                    w_tail_next  = w_in_entry;
                    w_state_next = StTwo;
                end else if (w_pop) begin
                    w_state_next = StEmpty;
                end
            end
            StTwo: begin
                // in_ready is low here, so only a pop can happen
                if (w_pop) begin
                    w_head_next  = r_tail;
                    w_state_next = StOne;
                end
            end
            default: w_state_next = StEmpty;
        endcase
    end

    // FIFO state, storage and registered in_ready (low whenever the FIFO will be full).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StEmpty;
            r_head     <= '0;
            r_tail     <= '0;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_head     <= w_head_next;
            r_tail     <= w_tail_next;
            r_in_ready <= (w_state_next != StTwo);
        end
    end

    // Running sum and count of popped words; clear restarts them, counting a same-cycle pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum   <= '0;
            r_count <= '0;
        end else if (clear) begin
            r_sum   <= w_pop ? w_head_ext : '0;
            r_count <= w_pop ? CNT_W'(1) : '0;
        end else if (w_pop) begin
            r_sum   <= r_sum + w_head_ext;
            r_count <= r_count + CNT_W'(1);
        end
    end

`ifdef SIGNAL_CONSUMER_PARITY_EN
    logic r_parity_err;
    logic w_parity_bad;

    assign w_parity_bad = r_head[DATA_W] ^ (^r_head[DATA_W-1:0]);
    assign parity_err   = r_parity_err;

    // Sticky parity error; clear drops the old flag but a bad word popped with it still sets it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= (r_parity_err & ~clear) | (w_pop & w_parity_bad);
        end
    end
`endif

endmodule

// File: tb/tb_signal_consumer.sv
// Self-checking bench for signal_consumer: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_signal_consumer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b0;
    logic       clear = 1'b0;
    logic       in_parity = 1'b0;

    logic        in_ready, out_valid;
    logic [7:0]  out_data;
    logic [15:0] sum, count;
    logic        in_ready8, out_valid8;
    logic [7:0]  out_data8;
    logic [7:0]  sum8, count8;
`ifdef SIGNAL_CONSUMER_PARITY_EN
    logic        parity_err, parity_err8;
`endif

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    signal_consumer #(.DATA_W(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .clear(clear),
`ifdef SIGNAL_CONSUMER_PARITY_EN
        .in_parity(in_parity), .parity_err(parity_err),
`endif
        .sum(sum), .count(count)
    );

    signal_consumer #(.DATA_W(8), .CNT_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready8),
        .out_valid(out_valid8), .out_data(out_data8), .out_ready(out_ready), .clear(clear),
`ifdef SIGNAL_CONSUMER_PARITY_EN
        .in_parity(in_parity), .parity_err(parity_err8),
`endif
        .sum(sum8), .count(count8)
    );

    // Reference model: a queue of {parity, data}, plain arithmetic for sum/count.
    logic [8:0]  m_q[$];
    logic        m_rdy;
    logic [15:0] m_sum, m_cnt;
    logic        m_perr;

    always @(posedge clk or posedge rst) begin
        logic [8:0] head;
        logic       do_push, do_pop;
        if (rst) begin
            m_q.delete();
            m_rdy  = 1'b1;
            m_sum  = '0;
            m_cnt  = '0;
            m_perr = 1'b0;
        end else begin
            do_push = in_valid && m_rdy;
            do_pop  = (m_q.size() != 0) && out_ready;
            head    = 9'h0;
            if (do_pop) head = m_q.pop_front();
            if (clear) begin
                m_sum  = do_pop ? {8'h00, head[7:0]} : 16'h0;
                m_cnt  = do_pop ? 16'd1 : 16'd0;
                m_perr = 1'b0;
            end else if (do_pop) begin
                m_sum = m_sum + {8'h00, head[7:0]};
                m_cnt = m_cnt + 16'd1;
            end
            if (do_pop && (head[8] != ^head[7:0])) m_perr = 1'b1;
            if (do_push) m_q.push_back({in_parity, in_data});
            m_rdy = (m_q.size() != 2);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("cyc_in_ready", {31'b0, in_ready}, {31'b0, m_rdy});
            chk("cyc_out_valid", {31'b0, out_valid}, {31'b0, m_q.size() != 0});
            if (m_q.size() != 0) chk("cyc_out_data", {24'b0, out_data}, {24'b0, m_q[0][7:0]});
            chk("cyc_sum", {16'b0, sum}, {16'b0, m_sum});
            chk("cyc_count", {16'b0, count}, {16'b0, m_cnt});
            chk("cyc_sum8", {24'b0, sum8}, {24'b0, m_sum[7:0]});
            chk("cyc_count8", {24'b0, count8}, {24'b0, m_cnt[7:0]});
`ifdef SIGNAL_CONSUMER_PARITY_EN
            chk("cyc_parity_err", {31'b0, parity_err}, {31'b0, m_perr});
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        in_valid  = v;
        in_data   = d;
        in_parity = ^d;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", {24'b0, out_data}, 32'h0);
        chk("rst_sum", {16'b0, sum}, 32'h0);
        chk("rst_count", {16'b0, count}, 32'h0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // In-order flow with one-cycle latency
        out_ready = 1'b1;
        drive(1'b1, 8'h11); step();
        chk("flow_d0", {24'b0, out_data}, 32'h11);
        drive(1'b1, 8'h22); step();
        chk("flow_d1", {24'b0, out_data}, 32'h22);
        drive(1'b1, 8'h33); step();
        chk("flow_d2", {24'b0, out_data}, 32'h33);
        drive(1'b0, 8'h00); step();
        chk("flow_empty", {31'b0, out_valid}, 32'd0);
        chk("flow_sum", {16'b0, sum}, 32'h66);
        chk("flow_count", {16'b0, count}, 32'd3);

        // Backpressure: fill, blocked third push, drain
        out_ready = 1'b0;
        drive(1'b1, 8'hA0); step();
        chk("bp_rdy1", {31'b0, in_ready}, 32'd1);
        drive(1'b1, 8'hA1); step();
        chk("bp_full", {31'b0, in_ready}, 32'd0);
        drive(1'b1, 8'hA2); step();
        chk("bp_blocked", {31'b0, in_ready}, 32'd0);
        chk("bp_head", {24'b0, out_data}, 32'hA0);
        drive(1'b0, 8'h00); out_ready = 1'b1; step();
        chk("bp_rdy_back", {31'b0, in_ready}, 32'd1);
        chk("bp_pop2", {24'b0, out_data}, 32'hA1);
        step();
        chk("bp_drained", {31'b0, out_valid}, 32'd0);
        chk("bp_count", {16'b0, count}, 32'd5);

        // Sum wrap on the narrow instance
        out_ready = 1'b0; clear = 1'b1; step(); clear = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 8'hFF); step();
        drive(1'b1, 8'hFF); step();
        drive(1'b0, 8'h00); step();
        chk("wrap_sum8", {24'b0, sum8}, 32'hFE);
        chk("wrap_count8", {24'b0, count8}, 32'd2);
        chk("wrap_sum16", {16'b0, sum}, 32'h1FE);

        // Clear coinciding with a pop
        clear = 1'b1; out_ready = 1'b0; step(); clear = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 8'h40); step();
        drive(1'b0, 8'h00); step();
        chk("clr_prior", {16'b0, sum}, 32'h40);
        out_ready = 1'b0;
        drive(1'b1, 8'h05); step();
        drive(1'b1, 8'h07); step();
        drive(1'b0, 8'h00); out_ready = 1'b1; clear = 1'b1; step(); clear = 1'b0;
        chk("clr_sum", {16'b0, sum}, 32'h05);
        chk("clr_count", {16'b0, count}, 32'd1);
        chk("clr_fifo", {24'b0, out_data}, 32'h07);
        step();
        chk("clr_after", {16'b0, sum}, 32'h0C);

        // Asynchronous reset while full
        out_ready = 1'b0;
        drive(1'b1, 8'hB1); step();
        drive(1'b1, 8'hB2); step();
        drive(1'b0, 8'h00);
        #1 rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("arst_sum", {16'b0, sum}, 32'h0);
        rst = 1'b0;
        drive(1'b1, 8'hC3); step();
        chk("post_rst_push", {24'b0, out_data}, 32'hC3);
        drive(1'b0, 8'h00); out_ready = 1'b1; step();
        chk("post_rst_gone", {31'b0, out_valid}, 32'd0);
        chk("post_rst_sum", {16'b0, sum}, 32'hC3);

`ifdef SIGNAL_CONSUMER_PARITY_EN
        clear = 1'b1; step(); clear = 1'b0;
        drive(1'b1, 8'h03); in_parity = 1'b1; step();
        drive(1'b0, 8'h00); step();
        chk("par_set", {31'b0, parity_err}, 32'd1);
        step();
        chk("par_sticky", {31'b0, parity_err}, 32'd1);
        clear = 1'b1; step(); clear = 1'b0;
        chk("par_clear", {31'b0, parity_err}, 32'd0);
`endif

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            in_parity = (^in_data) ^ ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            clear     = ($urandom_range(0, 40) == 0);
            step();
            if ($urandom_range(0, 300) == 0) begin
                rst = 1'b1;
                #1 rst = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/signal_consumer.md
SIGNAL_CONSUMER -- requirements
Module: signal_consumer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the stream data width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the sum and count outputs.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: upstream data valid.
REQ-006 The block SHALL have port in_data, input, DATA_W bits: upstream data.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block can accept a word; registered.
REQ-008 The block SHALL have port out_valid, output, 1 bit: head word available downstream.
REQ-009 The block SHALL have port out_data, output, DATA_W bits: head word.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream consumes the head word.
REQ-011 The block SHALL have port clear, input, 1 bit: synchronous clear of sum and count.
REQ-012 The block SHALL have port sum, output, CNT_W bits: running sum of consumed words.
REQ-013 The block SHALL have port count, output, CNT_W bits: number of consumed words.

Function
REQ-014 The block SHALL define a push as in_valid and in_ready both high at a clock edge, and a pop as out_valid and out_ready both high at a clock edge.
REQ-015 The block SHALL hold words in a 2-entry FIFO with states EMPTY, ONE and TWO.
REQ-016 The FIFO state SHALL move EMPTY->ONE on push; ONE->TWO on push without pop; ONE->EMPTY on pop without push; TWO->ONE on pop; and hold otherwise, including ONE with simultaneous push and pop.
REQ-017 The block SHALL drive in_ready low exactly when the next state is TWO, so in_ready is low while the FIFO is full and a push in TWO cannot occur.
REQ-018 The block SHALL drive out_valid high exactly when the state is not EMPTY, with out_data equal to the oldest stored word.
REQ-019 A word pushed at edge N SHALL be visible on out_data after edge N, with 1-cycle latency; there is no combinational in-to-out path.
REQ-020 The block SHALL preserve word order with no loss or duplication.
REQ-021 On each pop the block SHALL update sum <= sum + zero-extended out_data, wrapping modulo 2^CNT_W.
REQ-022 On each pop the block SHALL update count <= count + 1, wrapping modulo 2^CNT_W.
REQ-023 When clear is high without a pop, the block SHALL load sum and count with 0.
REQ-024 When clear is high with a pop, the block SHALL load sum with out_data and count with 1.
REQ-025 Clear SHALL NOT affect the FIFO contents or the handshake signals.
REQ-026 When out_valid is high and out_ready is low, out_valid and out_data SHALL remain stable.

Reset
REQ-027 While rst is high, the block SHALL force the state to EMPTY, in_ready to 1, out_valid to 0, out_data to 0, sum to 0 and count to 0.
REQ-028 Reset asserted mid-operation SHALL discard stored words immediately, asynchronously.
REQ-029 After rst deasserts, a push SHALL be accepted at the first clock edge.

Configuration
REQ-030 When macro SIGNAL_CONSUMER_PARITY_EN is defined, the block SHALL add input in_parity (1 bit, even parity over in_data, stored alongside the word) and output parity_err (1 bit).
REQ-031 With SIGNAL_CONSUMER_PARITY_EN defined, parity_err SHALL set on a pop whose stored parity mismatches, stay sticky until rst or clear, and reset to 0.
REQ-032 When SIGNAL_CONSUMER_PARITY_EN is not defined, the block SHALL have neither port, SHALL store no parity bits, and SHALL otherwise behave identically.

Verification
REQ-033 The bench SHALL cover: after reset, push 0x11, 0x22, 0x33 with out_ready=1 -> out_data sequence 0x11, 0x22, 0x33 each one cycle after its push; sum=0x66; count=3.
REQ-034 The bench SHALL cover: out_ready=0, push 0xA0, 0xA1 -> in_ready low after the second push, third in_valid not accepted; out_ready=1 -> 0xA0 then 0xA1 pop, and in_ready returns high the cycle after the first pop.
REQ-035 The bench SHALL cover: CNT_W=8, pop 0xFF twice -> sum=0xFE, count=2.
REQ-036 The bench SHALL cover: clear asserted in the same cycle as a pop of 0x05 with prior sum=0x40 -> sum=0x05, count=1; FIFO contents unchanged.
REQ-037 The bench SHALL cover: FIFO in state TWO, rst pulsed between clock edges -> out_valid=0 and in_ready=1 immediately; stored words never appear.
REQ-038 The bench SHALL cover, with SIGNAL_CONSUMER_PARITY_EN: push 0x03 with in_parity=1 -> parity_err=1 after its pop, remaining 1 until clear.
